// File: rtl/wb_mem_2_ppfifo.sv
// Streams words from two ping-pong memory banks (Wishbone master reads) into a ping-pong FIFO.
// Define WB_MEM_2_PPFIFO_BYTE_ADDR_EN to make o_mem_adr step by 4 per word (byte addressing).
module wb_mem_2_ppfifo (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_enable,

  input  logic [31:0] i_memory_0_base,
  input  logic [31:0] i_memory_0_size,
  input  logic        i_memory_0_new_data,
  output logic [31:0] o_memory_0_count,
  output logic        o_memory_0_empty,

  input  logic [31:0] i_memory_1_base,
  input  logic [31:0] i_memory_1_size,
  input  logic        i_memory_1_new_data,
  output logic [31:0] o_memory_1_count,
  output logic        o_memory_1_empty,

  output logic        o_read_finished,

  output logic        o_mem_we,
  output logic        o_mem_stb,
  output logic        o_mem_cyc,
  output logic [3:0]  o_mem_sel,
  output logic [31:0] o_mem_adr,
  output logic [31:0] o_mem_dat,
  input  logic [31:0] i_mem_dat,
  input  logic        i_mem_ack,
  input  logic        i_mem_int,

  input  logic [1:0]  i_ppfifo_rdy,
  output logic [1:0]  o_ppfifo_act,
  input  logic [23:0] i_ppfifo_size,
  output logic        o_ppfifo_stb,
  output logic [31:0] o_ppfifo_data
);

  typedef enum logic [1:0] {
    IDLE             = 2'd0,
    GET_MEMORY_BLOCK = 2'd1,
    READ_DATA        = 2'd2,
    FINISHED         = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] ptr0_q, ptr0_d;
  logic [31:0] ptr1_q, ptr1_d;
  logic        active_q, active_d;
  logic        ready_q, ready_d;
  logic [31:0] read_size_q, read_size_d;
  logic        cyc_q, cyc_d;
  logic        stb_q, stb_d;
  logic [1:0]  act_q, act_d;
  logic [23:0] wcount_q, wcount_d;
  logic        pstb_q, pstb_d;
  logic [31:0] pdata_q, pdata_d;
  logic        fin_q, fin_d;
  logic        empty0_q, empty1_q;

  logic [31:0] count0, count1;
  logic [31:0] act_base, act_ptr, act_count;
  logic        unused_ok;

  assign count0    = i_memory_0_size - ptr0_q;
  assign count1    = i_memory_1_size - ptr1_q;
  assign act_base  = active_q ? i_memory_1_base : i_memory_0_base;
  assign act_ptr   = active_q ? ptr1_q : ptr0_q;
  assign act_count = active_q ? count1 : count0;

`ifdef WB_MEM_2_PPFIFO_BYTE_ADDR_EN
  assign o_mem_adr = act_base + (act_ptr << 2);
`else
  assign o_mem_adr = act_base + act_ptr;
`endif

  assign o_memory_0_count = count0;
  assign o_memory_1_count = count1;
  assign o_memory_0_empty = empty0_q;
  assign o_memory_1_empty = empty1_q;
  assign o_read_finished  = fin_q;
  assign o_mem_we         = 1'b0;
  assign o_mem_sel        = 4'hF;
  assign o_mem_dat        = 32'h0;
  assign o_mem_cyc        = cyc_q;
  assign o_mem_stb        = stb_q;
  assign o_ppfifo_act     = act_q;
  assign o_ppfifo_stb     = pstb_q;
  assign o_ppfifo_data    = pdata_q;
  assign unused_ok        = i_mem_int;

  always_comb begin
    state_d     = state_q;
    ptr0_d      = ptr0_q;
    ptr1_d      = ptr1_q;
    active_d    = active_q;
    ready_d     = ready_q;
    read_size_d = read_size_q;
    cyc_d       = cyc_q;
    stb_d       = stb_q;
    act_d       = act_q;
    wcount_d    = wcount_q;
    pstb_d      = 1'b0;
    pdata_d     = pdata_q;
    fin_d       = 1'b0;

    // Bank 0 has priority whenever a fresh block is chosen.
    if (!ready_q) begin
      if (count0 != 32'd0) begin
        active_d = 1'b0;
        ready_d  = 1'b1;
      end else if (count1 != 32'd0) begin
        active_d = 1'b1;
        ready_d  = 1'b1;
      end
    end else if (act_count == 32'd0) begin
      ready_d = 1'b0;
    end

    if (i_enable && (act_q == 2'b00) && (i_ppfifo_rdy != 2'b00)) begin
      act_d    = i_ppfifo_rdy[0] ? 2'b01 : 2'b10;
      wcount_d = 24'd0;
    end

    case (state_q)
      IDLE: begin
        cyc_d = 1'b0;
        stb_d = 1'b0;
        if (i_enable) state_d = GET_MEMORY_BLOCK;
      end
      GET_MEMORY_BLOCK: begin
        cyc_d = 1'b0;
        stb_d = 1'b0;
        if (ready_q) begin
          read_size_d = active_q ? i_memory_1_size : i_memory_0_size;
          state_d     = READ_DATA;
        end else if (!i_enable) begin
          state_d = IDLE;
        end
      end
      READ_DATA: begin
        // An outstanding strobe is always allowed to complete before anything else.
        if (stb_q) begin
          if (i_mem_ack) begin
            pdata_d  = i_mem_dat;
            pstb_d   = 1'b1;
            stb_d    = 1'b0;
            wcount_d = wcount_q + 24'd1;
            if (active_q) ptr1_d = ptr1_q + 32'd1;
            else          ptr0_d = ptr0_q + 32'd1;
          end
        end else if (!i_enable) begin
          cyc_d = 1'b0;
          if ((act_q != 2'b00) && (wcount_q != 24'd0)) act_d = 2'b00;
          state_d = IDLE;
        end else if (act_ptr >= read_size_q) begin
          cyc_d   = 1'b0;
          fin_d   = 1'b1;
          state_d = FINISHED;
        end else if (act_q == 2'b00) begin
          cyc_d = 1'b0;
        end else if (wcount_q >= i_ppfifo_size) begin
          cyc_d = 1'b0;
          act_d = 2'b00;
        end else begin
          cyc_d = 1'b1;
          stb_d = 1'b1;
        end
      end
      FINISHED: begin
        cyc_d = 1'b0;
        stb_d = 1'b0;
        // Hand over a partially filled FIFO side rather than leaving it stranded.
        if ((act_q != 2'b00) && (wcount_q != 24'd0)) act_d = 2'b00;
        state_d = GET_MEMORY_BLOCK;
      end
      default: state_d = IDLE;
    endcase

    if (i_memory_0_new_data) ptr0_d = 32'd0;
    if (i_memory_1_new_data) ptr1_d = 32'd0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      ptr0_q      <= 32'd0;
      ptr1_q      <= 32'd0;
      active_q    <= 1'b0;
      ready_q     <= 1'b0;
      read_size_q <= 32'd0;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      act_q       <= 2'b00;
      wcount_q    <= 24'd0;
      pstb_q      <= 1'b0;
      pdata_q     <= 32'd0;
      fin_q       <= 1'b0;
      empty0_q    <= 1'b1;
      empty1_q    <= 1'b1;
    end else begin
      state_q     <= state_d;
      ptr0_q      <= ptr0_d;
      ptr1_q      <= ptr1_d;
      active_q    <= active_d;
      ready_q     <= ready_d;
      read_size_q <= read_size_d;
      cyc_q       <= cyc_d;
      stb_q       <= stb_d;
      act_q       <= act_d;
      wcount_q    <= wcount_d;
      pstb_q      <= pstb_d;
      pdata_q     <= pdata_d;
      fin_q       <= fin_d;
      empty0_q    <= (count0 == 32'd0);
      empty1_q    <= (count1 == 32'd0);
    end
  end

endmodule
